// File: rtl/axi_req_loader.sv
// AXI read-request loader: fetches A/B/C matrix bursts over AXI and writes the first recvbits of payload into SRAM.
// Optional watchdog on stalled AXI handshakes is compiled in with AXI_LOADER_TIMEOUT_EN.
module axi_req_loader #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRAM_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [31:0]        a_base,
  input  logic [31:0]        b_base,
  input  logic [31:0]        c_base,
  input  logic [31:0]        d_base,
  input  logic [2:0]         sel,
  input  logic [31:0]        recvbits,
  input  logic [4:0]         burst_num,
  input  logic [7:0]         burst_size,
  output logic               busy,
  output logic               finish,
  output logic               err,
  output logic [ADDR_W-1:0]  araddr,
  output logic [7:0]         arlen,
  output logic               arvalid,
  input  logic               arready,
  input  logic [DATA_W-1:0]  rdata,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic               sram_we,
  output logic [2:0]         sram_sel,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic              skip;
  logic [31:0]       recvbits_q;
  logic [31:0]       rx_bits;
  logic [4:0]        burst_num_q;
  logic [4:0]        burst_idx;
  logic [7:0]        burst_size_q;
  logic [7:0]        beat_cnt;

  logic              sel_ok;
  logic [ADDR_W-1:0] req_base;
  logic              beat;
  logic              exp_last;
  logic              burst_end;
  logic              last_burst;

  // D is the write path and is never fetched here.
  logic              unused_d_base;
  always_comb unused_d_base = ^d_base;

  always_comb begin
    sel_ok   = 1'b1;
    req_base = '0;
    case (sel)
      3'b100:  req_base = ADDR_W'(a_base);
      3'b010:  req_base = ADDR_W'(b_base);
      3'b001:  req_base = ADDR_W'(c_base);
      default: sel_ok   = 1'b0;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    finish     = (state == S_DONE);
    arvalid    = (state == S_ADDR) && !skip;
    rready     = (state == S_DATA);
    beat       = rready && rvalid;
    sram_we    = beat && (rx_bits < recvbits_q);
    sram_wdata = sram_we ? rdata : '0;
    exp_last   = (beat_cnt == burst_size_q - 8'd1);
    burst_end  = beat && (rlast || exp_last);
    last_burst = (burst_idx == burst_num_q - 5'd1);
  end

`ifdef AXI_LOADER_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_stall;
  logic       wd_hit;

  always_comb begin
    wd_stall = (arvalid && !arready) || (rready && !rvalid);
    wd_hit   = wd_stall && (wd_cnt == 8'd254);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        wd_cnt <= '0;
    else if (wd_stall) wd_cnt <= wd_cnt + 8'd1;
    else               wd_cnt <= '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      skip         <= 1'b0;
      err          <= 1'b0;
      araddr       <= '0;
      arlen        <= '0;
      sram_sel     <= '0;
      sram_addr    <= '0;
      recvbits_q   <= '0;
      rx_bits      <= '0;
      burst_num_q  <= '0;
      burst_idx    <= '0;
      burst_size_q <= '0;
      beat_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            // Invalid requests still pass through ADDR (with arvalid low) so the
            // caller always sees finish two cycles after a rejected request.
            skip         <= !sel_ok || (burst_num == 5'd0) || (burst_size == 8'd0);
            err          <= !sel_ok;
            araddr       <= req_base;
            arlen        <= burst_size - 8'd1;
            sram_sel     <= sel;
            sram_addr    <= '0;
            recvbits_q   <= recvbits;
            rx_bits      <= '0;
            burst_num_q  <= burst_num;
            burst_idx    <= '0;
            burst_size_q <= burst_size;
            beat_cnt     <= '0;
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (skip) begin
            state <= S_DONE;
          end else if (arready) begin
            beat_cnt <= '0;
            state    <= S_DATA;
          end
`ifdef AXI_LOADER_TIMEOUT_EN
          else if (wd_hit) begin
            err   <= 1'b1;
            state <= S_DONE;
          end
`endif
        end
        S_DATA: begin
          if (beat) begin
            rx_bits  <= rx_bits + 32'(DATA_W);
            beat_cnt <= beat_cnt + 8'd1;
            if (sram_we) sram_addr <= sram_addr + SRAM_AW'(1);
            if (burst_end) begin
              if (rlast != exp_last) err <= 1'b1;
              if (last_burst) begin
                state <= S_DONE;
              end else begin
                // Address advances incrementally: base + idx*burst_size*4.
                burst_idx <= burst_idx + 5'd1;
                araddr    <= araddr + ADDR_W'({burst_size_q, 2'b00});
                state     <= S_ADDR;
              end
            end
          end
`ifdef AXI_LOADER_TIMEOUT_EN
          else if (wd_hit) begin
            err   <= 1'b1;
            state <= S_DONE;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_req_loader.sv
// Directed self-checking bench for axi_req_loader with a reactive AXI read slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_req_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] a_base, b_base, c_base, d_base;
  logic [2:0]  sel;
  logic [31:0] recvbits;
  logic [4:0]  burst_num;
  logic [7:0]  burst_size;
  logic        busy, finish, err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;
  logic        sram_we;
  logic [2:0]  sram_sel;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] ar_addr[$];
  logic [7:0]  ar_len[$];
  logic [9:0]  we_addr[$];
  logic [31:0] we_data[$];
  int          beats, first_ar_cyc, finish_cyc, last_beat_cyc, ar_unstable;
  logic        fin_err, busy_at_req;
  logic [2:0]  fin_sel;

  always #5 clk = ~clk;

  axi_req_loader #(.ADDR_W(32), .DATA_W(32), .SRAM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .d_base(d_base),
    .sel(sel), .recvbits(recvbits), .burst_num(burst_num), .burst_size(burst_size),
    .busy(busy), .finish(finish), .err(err),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_we(sram_we), .sram_sel(sram_sel), .sram_addr(sram_addr), .sram_wdata(sram_wdata)
  );

  // Issues one request (cycle 0) and plays the slave until finish or max_cyc.
  // rlast_at: beat within a burst that carries rlast (0 = never).
  // ar_wait: cycles arvalid must be held before arready. dup: extra req_valid at cycle 3.
  task automatic run_req(input logic [2:0] s, input logic [31:0] rb, input logic [4:0] bn,
                         input logic [7:0] bs, input int rlast_at, input int ar_wait,
                         input int max_cyc, input bit dup);
    int          bib, held_cnt;
    logic [31:0] held_addr;
    logic [7:0]  held_len;
    ar_addr.delete(); ar_len.delete(); we_addr.delete(); we_data.delete();
    beats = 0; first_ar_cyc = -1; finish_cyc = -1; last_beat_cyc = -1; ar_unstable = 0;
    fin_err = 1'b0; fin_sel = 3'b000; bib = 0; held_cnt = 0; held_addr = '0; held_len = '0;
    @(negedge clk);
    sel = s; recvbits = rb; burst_num = bn; burst_size = bs; req_valid = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    #1 busy_at_req = busy;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (dup && n == 3) begin
        req_valid = 1'b1; sel = 3'b100; burst_size = 8'd1;
      end
      arready = arvalid && (held_cnt >= ar_wait);
      rvalid  = rready;
      rlast   = rready && (rlast_at > 0) && (bib + 1 == rlast_at);
      rdata   = rready ? 32'hD000_0000 + beats : 32'h0;
      #1;
      if (arvalid) begin
        if (first_ar_cyc < 0) first_ar_cyc = n;
        if (held_cnt == 0) begin
          held_addr = araddr; held_len = arlen;
        end else if (araddr !== held_addr || arlen !== held_len) begin
          ar_unstable++;
        end
        if (arready) begin
          ar_addr.push_back(araddr); ar_len.push_back(arlen);
          held_cnt = 0; bib = 0;
        end else begin
          held_cnt++;
        end
      end
      if (sram_we) begin
        we_addr.push_back(sram_addr); we_data.push_back(sram_wdata);
      end
      if (rvalid && rready) begin
        beats++; bib++; last_beat_cyc = n;
      end
      if (finish) begin
        finish_cyc = n; fin_err = err; fin_sel = sram_sel;
        break;
      end
    end
    req_valid = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b1; sel = 3'b100; burst_num = 5'd1; burst_size = 8'd1;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++; if ({busy, finish, err, arvalid, rready, sram_we} !== 6'b0) $display("FAIL rst_ctrl: got %b expected 000000", {busy, finish, err, arvalid, rready, sram_we}); else pass_cnt++;
    chk_cnt++; if ({araddr, arlen} !== 40'h0) $display("FAIL rst_ar: got %0h expected 0", {araddr, arlen}); else pass_cnt++;
    chk_cnt++; if ({sram_addr, sram_wdata, sram_sel} !== 45'h0) $display("FAIL rst_sram: got %0h expected 0", {sram_addr, sram_wdata, sram_sel}); else pass_cnt++;
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_two_bursts;
    int bad;
    run_req(3'b100, 32'd512, 5'd2, 8'd8, 8, 0, 60, 1'b0);
    chk_cnt++; if (first_ar_cyc !== 1) $display("FAIL tb_first_ar_cyc: got %0d expected 1", first_ar_cyc); else pass_cnt++;
    chk_cnt++; if (ar_addr.size() !== 2) $display("FAIL tb_ar_count: got %0d expected 2", ar_addr.size()); else pass_cnt++;
    if (ar_addr.size() == 2) begin
      chk_cnt++; if (ar_addr[0] !== 32'h0 || ar_addr[1] !== 32'h20) $display("FAIL tb_araddr: got %0h,%0h expected 0,20", ar_addr[0], ar_addr[1]); else pass_cnt++;
      chk_cnt++; if (ar_len[0] !== 8'd7 || ar_len[1] !== 8'd7) $display("FAIL tb_arlen: got %0d,%0d expected 7,7", ar_len[0], ar_len[1]); else pass_cnt++;
    end
    chk_cnt++; if (we_addr.size() !== 16) $display("FAIL tb_we_count: got %0d expected 16", we_addr.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < we_addr.size(); i++)
      if (bad < 0 && (we_addr[i] !== 10'(i) || we_data[i] !== 32'hD000_0000 + i)) bad = i;
    chk_cnt++;
    if (bad >= 0) $display("FAIL tb_we_seq: got addr %0d data %0h expected addr %0d data %0h", we_addr[bad], we_data[bad], bad, 32'hD000_0000 + bad);
    else pass_cnt++;
    chk_cnt++; if (finish_cyc !== 19) $display("FAIL tb_finish_cyc: got %0d expected 19", finish_cyc); else pass_cnt++;
    chk_cnt++; if (finish_cyc !== last_beat_cyc + 1) $display("FAIL tb_finish_after_rlast: got %0d expected %0d", finish_cyc, last_beat_cyc + 1); else pass_cnt++;
    chk_cnt++; if (fin_err !== 1'b0) $display("FAIL tb_err: got %b expected 0", fin_err); else pass_cnt++;
    chk_cnt++; if (fin_sel !== 3'b100) $display("FAIL tb_sram_sel: got %b expected 100", fin_sel); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if ({busy, finish} !== 2'b00) $display("FAIL tb_idle_after: got %b expected 00", {busy, finish}); else pass_cnt++;
  endtask

  task automatic test_recvbits_limit;
    run_req(3'b010, 32'd320, 5'd1, 8'd16, 16, 0, 60, 1'b0);
    chk_cnt++; if (ar_addr.size() !== 1 || ar_addr[0] !== 32'h4000 || ar_len[0] !== 8'd15) $display("FAIL rl_ar: got n=%0d addr %0h len %0d expected n=1 addr 4000 len 15", ar_addr.size(), ar_addr[0], ar_len[0]); else pass_cnt++;
    chk_cnt++; if (beats !== 16) $display("FAIL rl_beats: got %0d expected 16", beats); else pass_cnt++;
    chk_cnt++; if (we_addr.size() !== 10) $display("FAIL rl_we_count: got %0d expected 10", we_addr.size()); else pass_cnt++;
    if (we_addr.size() == 10) begin
      chk_cnt++; if (we_addr[9] !== 10'd9 || we_data[9] !== 32'hD000_0009) $display("FAIL rl_we_last: got %0d/%0h expected 9/d0000009", we_addr[9], we_data[9]); else pass_cnt++;
    end
    chk_cnt++; if (finish_cyc !== 18 || fin_err !== 1'b0) $display("FAIL rl_finish: got cyc %0d err %b expected cyc 18 err 0", finish_cyc, fin_err); else pass_cnt++;
  endtask

  task automatic test_bad_request;
    run_req(3'b000, 32'd32, 5'd1, 8'd4, 4, 0, 20, 1'b0);
    chk_cnt++; if (finish_cyc !== 2 || fin_err !== 1'b1) $display("FAIL sel000_finish: got cyc %0d err %b expected cyc 2 err 1", finish_cyc, fin_err); else pass_cnt++;
    chk_cnt++; if (first_ar_cyc !== -1) $display("FAIL sel000_no_ar: got first arvalid cyc %0d expected none (-1)", first_ar_cyc); else pass_cnt++;
    run_req(3'b110, 32'd32, 5'd1, 8'd4, 4, 0, 20, 1'b0);
    chk_cnt++; if (finish_cyc !== 2 || fin_err !== 1'b1 || first_ar_cyc !== -1) $display("FAIL sel110: got cyc %0d err %b ar %0d expected cyc 2 err 1 ar -1", finish_cyc, fin_err, first_ar_cyc); else pass_cnt++;
    run_req(3'b100, 32'd32, 5'd0, 8'd4, 4, 0, 20, 1'b0);
    chk_cnt++; if (finish_cyc !== 2 || fin_err !== 1'b0 || first_ar_cyc !== -1) $display("FAIL zero_bursts: got cyc %0d err %b ar %0d expected cyc 2 err 0 ar -1", finish_cyc, fin_err, first_ar_cyc); else pass_cnt++;
    run_req(3'b001, 32'd32, 5'd1, 8'd0, 4, 0, 20, 1'b0);
    chk_cnt++; if (finish_cyc !== 2 || fin_err !== 1'b0 || first_ar_cyc !== -1) $display("FAIL zero_size: got cyc %0d err %b ar %0d expected cyc 2 err 0 ar -1", finish_cyc, fin_err, first_ar_cyc); else pass_cnt++;
  endtask

  task automatic test_early_rlast;
    run_req(3'b010, 32'd512, 5'd1, 8'd4, 2, 0, 40, 1'b1);
    chk_cnt++; if (beats !== 2 || we_addr.size() !== 2) $display("FAIL er_beats: got beats %0d we %0d expected 2 2", beats, we_addr.size()); else pass_cnt++;
    chk_cnt++; if (finish_cyc !== 4 || fin_err !== 1'b1) $display("FAIL er_finish: got cyc %0d err %b expected cyc 4 err 1", finish_cyc, fin_err); else pass_cnt++;
    chk_cnt++; if (ar_addr.size() !== 1) $display("FAIL er_ar_count: got %0d expected 1", ar_addr.size()); else pass_cnt++;
    repeat (2) begin
      @(negedge clk); #1;
      chk_cnt++; if ({busy, arvalid} !== 2'b00) $display("FAIL er_dup_ignored: got busy/arvalid %b expected 00", {busy, arvalid}); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    run_req(3'b100, 32'd512, 5'd1, 8'd4, 0, 0, 40, 1'b0);
    chk_cnt++; if (beats !== 4 || finish_cyc !== 6 || fin_err !== 1'b1) $display("FAIL nr_missing_rlast: got beats %0d cyc %0d err %b expected 4 6 1", beats, finish_cyc, fin_err); else pass_cnt++;
    run_req(3'b100, 32'd32, 5'd1, 8'd1, 1, 0, 40, 1'b0);
    chk_cnt++; if (busy_at_req !== 1'b0 || first_ar_cyc !== 1) $display("FAIL b2b_accept: got busy %b ar cyc %0d expected 0 1", busy_at_req, first_ar_cyc); else pass_cnt++;
    chk_cnt++; if (we_addr.size() !== 1 || we_addr[0] !== 10'd0) $display("FAIL b2b_sram_restart: got n=%0d addr %0d expected n=1 addr 0", we_addr.size(), we_addr[0]); else pass_cnt++;
    chk_cnt++; if (finish_cyc !== 3 || fin_err !== 1'b0) $display("FAIL b2b_finish: got cyc %0d err %b expected cyc 3 err 0", finish_cyc, fin_err); else pass_cnt++;
  endtask

  task automatic test_ar_stall;
    run_req(3'b001, 32'd64, 5'd2, 8'd4, 4, 3, 60, 1'b0);
    chk_cnt++; if (ar_unstable !== 0) $display("FAIL st_ar_stable: got %0d changes expected 0", ar_unstable); else pass_cnt++;
    chk_cnt++; if (ar_addr.size() !== 2 || ar_addr[0] !== 32'h8000 || ar_addr[1] !== 32'h8010) $display("FAIL st_araddr: got n=%0d %0h,%0h expected 2 8000,8010", ar_addr.size(), ar_addr[0], ar_addr[1]); else pass_cnt++;
    chk_cnt++; if (we_addr.size() !== 2) $display("FAIL st_we_count: got %0d expected 2", we_addr.size()); else pass_cnt++;
    chk_cnt++; if (finish_cyc !== 17 || fin_err !== 1'b0) $display("FAIL st_finish: got cyc %0d err %b expected cyc 17 err 0", finish_cyc, fin_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst;
    int nfin;
    @(negedge clk);
    sel = 3'b010; recvbits = 32'd256; burst_num = 5'd1; burst_size = 8'd8; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0; arready = 1'b1;
    @(negedge clk); arready = 1'b0; rvalid = 1'b1; rlast = 1'b0; rdata = 32'hA1;
    @(negedge clk); rdata = 32'hA2;
    @(negedge clk); rdata = 32'hA3; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; rvalid = 1'b0; rdata = '0; #1;
    chk_cnt++; if ({busy, finish, err, arvalid, rready, sram_we} !== 6'b0) $display("FAIL mr_ctrl: got %b expected 000000", {busy, finish, err, arvalid, rready, sram_we}); else pass_cnt++;
    chk_cnt++; if ({araddr, arlen} !== 40'h0) $display("FAIL mr_ar: got %0h expected 0", {araddr, arlen}); else pass_cnt++;
    chk_cnt++; if ({sram_addr, sram_wdata, sram_sel} !== 45'h0) $display("FAIL mr_sram: got %0h expected 0", {sram_addr, sram_wdata, sram_sel}); else pass_cnt++;
    nfin = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (finish) nfin++;
    end
    chk_cnt++; if (nfin !== 0) $display("FAIL mr_no_finish: got %0d finishes expected 0", nfin); else pass_cnt++;
    run_req(3'b010, 32'd64, 5'd1, 8'd2, 2, 0, 40, 1'b0);
    chk_cnt++; if (finish_cyc !== 4 || fin_err !== 1'b0 || we_addr.size() !== 2) $display("FAIL mr_recover: got cyc %0d err %b we %0d expected 4 0 2", finish_cyc, fin_err, we_addr.size()); else pass_cnt++;
  endtask

  task automatic test_watchdog;
    run_req(3'b100, 32'd32, 5'd1, 8'd4, 4, 1000, 300, 1'b0);
`ifdef AXI_LOADER_TIMEOUT_EN
    chk_cnt++; if (finish_cyc !== 256 || fin_err !== 1'b1) $display("FAIL wd_timeout: got cyc %0d err %b expected cyc 256 err 1", finish_cyc, fin_err); else pass_cnt++;
    chk_cnt++; if (ar_addr.size() !== 0) $display("FAIL wd_no_handshake: got %0d expected 0", ar_addr.size()); else pass_cnt++;
`else
    chk_cnt++; if (finish_cyc !== -1) $display("FAIL wd_absent: got finish cyc %0d expected none (-1)", finish_cyc); else pass_cnt++;
    chk_cnt++; if ({busy, arvalid} !== 2'b11) $display("FAIL wd_absent_waiting: got busy/arvalid %b expected 11", {busy, arvalid}); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif
  endtask

  initial begin
    a_base = 32'h0; b_base = 32'h4000; c_base = 32'h8000; d_base = 32'hC000;
    req_valid = 1'b0; sel = '0; recvbits = '0; burst_num = '0; burst_size = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rst_n = 1'b0;
    test_reset();
    test_two_bursts();
    test_recvbits_limit();
    test_bad_request();
    test_early_rlast();
    test_back_to_back();
    test_ar_stall();
    test_reset_mid_burst();
    test_watchdog();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/axi_req_loader.md
AXI_REQ_LOADER -- requirements
Module: axi_req_loader

Interface
REQ-001 SHALL have parameters, as name, default, meaning:
- ADDR_W, 32, AXI address width
- DATA_W, 32, beat width in bits (one FP32 word)
- SRAM_AW, 10, SRAM word-address width
REQ-002 SHALL have ports, as name, direction, width, meaning:
- clk  in  1  clock; one clock domain only
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request strobe from the systolic controller
- a_base / b_base / c_base / d_base  in  32 each  matrix base byte addresses
- sel  in  3  100=A, 010=B, 001=C, 000=D
- recvbits  in  32  total payload bits to keep
- burst_num  in  5  number of bursts
- burst_size  in  8  beats per burst
- busy  out  1  request in progress
- finish  out  1  one-cycle completion pulse
- err  out  1  error flag, valid while finish=1
- araddr  out  ADDR_W  AXI read address
- arlen  out  8  AXI burst length
- arvalid  out  1  AXI read-address valid
- arready  in  1  AXI read-address ready
- rdata  in  DATA_W  AXI read data
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI read-data valid
- rready  out  1  AXI read-data ready
- sram_we  out  1  SRAM write enable
- sram_sel  out  3  SRAM select, copy of the latched sel
- sram_addr  out  SRAM_AW  SRAM word address
- sram_wdata  out  DATA_W  SRAM write data

Function
REQ-003 SHALL implement the states IDLE, ADDR, DATA and DONE.
REQ-004 In IDLE, req_valid=1 SHALL latch all request fields, set busy=1, and move to ADDR on the next cycle. req_valid SHALL be ignored while busy=1.
REQ-005 The latched base address SHALL follow sel: 100→a_base, 010→b_base, 001→c_base. Any other sel value, including 000 (D, the write path, which this block does not serve), SHALL go directly to DONE with err=1 and issue no AXI traffic.
REQ-006 If burst_num=0 or burst_size=0, the block SHALL go directly to DONE with err=0 and issue no AXI traffic.
REQ-007 In ADDR, arvalid SHALL be 1, with arlen=burst_size-1 and araddr=base+burst_idx*burst_size*4. araddr, arlen and arvalid SHALL hold stable until arready=1; the arready handshake moves the FSM to DATA.
REQ-008 In DATA, rready SHALL be 1. Each rvalid beat SHALL increment the 32-bit received-bits counter (rx_bits) by DATA_W.
REQ-009 A beat SHALL produce sram_we=1 in the same cycle only if rx_bits before the beat is less than recvbits. Beats beyond that point are accepted and discarded.
REQ-010 sram_addr SHALL start at 0 per request and increment by 1 per written word. It SHALL wrap modulo 2^SRAM_AW.
REQ-011 The rlast beat of a burst SHALL do one of two things:
- return to ADDR with burst_idx+1 if more bursts remain;
- otherwise move to DONE.
REQ-012 An rlast arriving before beat burst_size of a burst, or rlast missing on beat burst_size, SHALL set a sticky err. In both cases the burst ends at the beat where rlast or the expected count first occurs.
REQ-013 DONE SHALL last one cycle, with finish=1, err valid and busy=0 in the following IDLE. A req_valid in that IDLE cycle SHALL be accepted.
REQ-014 Latency: a zero-wait-state slave SHALL see the first arvalid 1 cycle after req_valid. finish SHALL assert 1 cycle after the final rlast.

Reset
REQ-015 rst_n=0 at a clk edge SHALL return the FSM to IDLE, including mid-burst.
REQ-016 On reset, all outputs SHALL be 0 (busy, finish, err, arvalid, rready, sram_we, araddr, arlen, sram_addr, sram_wdata, sram_sel), and all counters SHALL clear. No finish SHALL be produced for an aborted request.

Configuration
REQ-017 With macro AXI_LOADER_TIMEOUT_EN defined, an 8-bit watchdog SHALL count consecutive ADDR or DATA cycles with no handshake.
- At 255, the FSM SHALL go to DONE with err=1.
- The watchdog SHALL clear on any arready or rvalid handshake.
REQ-018 Without AXI_LOADER_TIMEOUT_EN, no watchdog logic SHALL exist and the block SHALL wait indefinitely.

Verification
REQ-019 sel=100, a_base=0x0, burst_num=2, burst_size=8, recvbits=512, zero-wait slave → araddr 0x0 then 0x20, arlen=7, 16 sram_we at addresses 0..15, finish with err=0.
REQ-020 sel=010, burst_num=1, burst_size=16, recvbits=320 → 16 beats accepted, sram_we only on the first 10, finish with err=0.
REQ-021 sel=000 or sel=110 → no arvalid, finish 2 cycles after req_valid with err=1.
REQ-022 burst_size=4 with rlast on beat 2 → burst ends after 2 beats, finish with err=1; second req_valid during busy is ignored.
REQ-023 rst_n low during DATA beat 3 → all outputs 0 next cycle, no finish; a new request afterwards completes normally.
REQ-024 AXI_LOADER_TIMEOUT_EN defined, arready held 0 → finish with err=1 exactly 255 ADDR cycles later. Without the macro, no finish is produced.
